inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer-side counterpart to the core's instruction decoder.
- Accepts a stream of symbolic instruction commands (op, rd, rs1, rs2, imm) over a valid/ready handshake.
- Encodes each command into a 32-bit RV32I word and writes it sequentially into instruction memory starting at word address 0.
- Used by the boot/test infrastructure to load programs before releasing the core.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width; capacity is 2^ADDR_WIDTH words.
- CPU_WIDTH, 32, instruction word width (matches `CPU_WIDTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  single-cycle pulse; begins or restarts a load session at address 0
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command ready
- cmd_op  input  4  operation select (encoding in Behaviour)
- cmd_rd  input  5  destination register
- cmd_rs1  input  5  source register 1
- cmd_rs2  input  5  source register 2
- cmd_imm  input  32  signed immediate/offset; for LUI, bits [31:12] are used
- cmd_last  input  1  marks the final command of a session
- mem_wen  output  1  instruction memory write enable
- mem_waddr  output  ADDR_WIDTH  word write address
- mem_wdata  output  CPU_WIDTH  encoded instruction
- busy  output  1  high while in LOAD
- done  output  1  high in DONE
- err  output  1  sticky error flag, cleared only by start or reset
- inst_cnt  output  ADDR_WIDTH+1  number of words written in this session

Behaviour:
- Reset: all outputs 0, pointer 0, FSM in IDLE.
- FSM states: IDLE, LOAD, DONE, FULL.
  - IDLE --start--> LOAD.
  - LOAD --accepted cmd_last--> DONE.
  - LOAD --accepted non-last command written to the top address--> FULL.
  - DONE/FULL --start--> LOAD.
- cmd_ready = 1 only in LOAD and when start = 0. A command is accepted when cmd_valid & cmd_ready.
- Write latency: a command accepted in cycle N produces mem_wen = 1 for exactly one cycle in N+1, with mem_waddr = pointer and mem_wdata = encoding. All three outputs are registered.
- Throughput: one command per cycle with no bubbles.
- Pointer and inst_cnt increment once per accepted command.
- Wrap: the pointer never wraps. After writing address 2^ADDR_WIDTH-1 with cmd_last = 0, the FSM enters FULL, sets err = 1 and holds cmd_ready low.
  - If that final accepted command has cmd_last = 1, the FSM goes to DONE with no error.
- start in any state:
  - pointer = 0, inst_cnt = 0, err = 0, FSM -> LOAD.
  - A handshake cannot occur in the same cycle because cmd_ready is low.
  - A write already registered from cycle N-1 still completes.
- Opcode map (cmd_op → fields):
  - 0 ADD: R-type, f3 000, f7 0000000.
  - 1 SUB: R-type, f3 000, f7 0100000.
  - 2 XOR: f3 100.
  - 3 OR: f3 110.
  - 4 AND: f3 111.
  - 5 SLL: f3 001.
  - R-type opcode is 0110011.
  - 6 ADDI: imm[11:0] | rs1 | 000 | rd | 0010011.
  - 7 BNE: imm[12] | imm[10:5] | rs2 | rs1 | 001 | imm[4:1] | imm[11] | 1100011.
  - 8 JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
  - 9 LUI: imm[31:12] | rd | 0110111.
- Unused fields: inputs not used by an instruction format are ignored.
- Immediates: truncated to the field width with no range check.
- Error conditions (sticky err = 1):
  - cmd_op 10–15: word written as NOP 0x00000013; the session continues.
  - BNE/JAL with cmd_imm[0] = 1 (misaligned): imm[0] is dropped and the word is still written.

Decomposition:
- Shared defines file:
  - LOADER_OP_* codes and LOADER_OP_WIDTH.
  - Funct3/funct7 constants.
  - INST_NOP constant.
  - Reuse of the existing INST_TYPE_R/I/B, INST_JAL and INST_LUI opcode constants.
- Sub-module inst_encode: purely combinational. Inputs are op/rd/rs1/rs2/imm; outputs are the 32-bit word and illegal/misaligned flags.
- inst_loader holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset, start, then ADD x3,x1,x2 then SUB x3,x1,x2 (last) -> writes 0x002081B3 @0 and 0x402081B3 @1; inst_cnt = 2; done = 1; err = 0.
- ADDI x1,x0,5; BNE x1,x2,-8; JAL x1,+16; LUI x5,0x12345000 (last) -> writes 0x00500093, 0xFE209CE3, 0x010000EF, 0x123452B7 at addresses 0–3, one per cycle, each write one cycle after acceptance.
- ADDR_WIDTH = 2, five commands with cmd_last = 0 -> four writes at addresses 0–3; FSM in FULL; err = 1; cmd_ready = 0; fifth command never accepted.
- cmd_op = 15 -> 0x00000013 written; err = 1 and stays set; subsequent ADD still written normally.
- start asserted while cmd_valid = 1 mid-session -> no acceptance that cycle; pointer = 0 and err = 0 next cycle; next command written to address 0.
- rst_n deasserted mid-write burst -> mem_wen, busy, done, err and inst_cnt go to 0 immediately (asynchronously); cmd_ready = 0 until the next start.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader: command codes,
// RV32I opcode/funct fields, the command payload and the loader FSM states.
package inst_loader_pkg;

    localparam int unsigned INST_WIDTH      = 32;
    localparam int unsigned LOADER_OP_WIDTH = 4;
    localparam int unsigned REG_WIDTH       = 5;

    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_ADD  = 4'd0;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_SUB  = 4'd1;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_XOR  = 4'd2;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_OR   = 4'd3;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_AND  = 4'd4;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_SLL  = 4'd5;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_ADDI = 4'd6;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_BNE  = 4'd7;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_JAL  = 4'd8;
    localparam logic [LOADER_OP_WIDTH-1:0] LOADER_OP_LUI  = 4'd9;

    localparam logic [6:0] INST_TYPE_R = 7'b0110011;
    localparam logic [6:0] INST_TYPE_I = 7'b0010011;
    localparam logic [6:0] INST_TYPE_B = 7'b1100011;
    localparam logic [6:0] INST_JAL    = 7'b1101111;
    localparam logic [6:0] INST_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [LOADER_OP_WIDTH-1:0] op;
        logic [REG_WIDTH-1:0]       rd;
        logic [REG_WIDTH-1:0]       rs1;
        logic [REG_WIDTH-1:0]       rs2;
        logic [INST_WIDTH-1:0]      imm;
    } loader_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FULL = 2'd3
    } loader_state_e;

endpackage

// File: rtl/inst_loader_encode.sv
// Combinational RV32I encoder for one loader command; flags unknown ops
// and misaligned branch/jump offsets.
module inst_loader_encode
    import inst_loader_pkg::*;
(
    input  loader_cmd_t           cmd,
    output logic [INST_WIDTH-1:0] word_c,
    output logic                  illegal_c,
    output logic                  misaligned_c
);

    always_comb begin
        word_c       = INST_NOP;
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        case (cmd.op)
            LOADER_OP_ADD: word_c = {F7_BASE, cmd.rs2, cmd.rs1, F3_ADD_SUB, cmd.rd, INST_TYPE_R};
            LOADER_OP_SUB: word_c = {F7_SUB,  cmd.rs2, cmd.rs1, F3_ADD_SUB, cmd.rd, INST_TYPE_R};
            LOADER_OP_XOR: word_c = {F7_BASE, cmd.rs2, cmd.rs1, F3_XOR,     cmd.rd, INST_TYPE_R};
            LOADER_OP_OR:  word_c = {F7_BASE, cmd.rs2, cmd.rs1, F3_OR,      cmd.rd, INST_TYPE_R};
            LOADER_OP_AND: word_c = {F7_BASE, cmd.rs2, cmd.rs1, F3_AND,     cmd.rd, INST_TYPE_R};
            LOADER_OP_SLL: word_c = {F7_BASE, cmd.rs2, cmd.rs1, F3_SLL,     cmd.rd, INST_TYPE_R};
            LOADER_OP_ADDI: word_c = {cmd.imm[11:0], cmd.rs1, F3_ADD_SUB, cmd.rd, INST_TYPE_I};
            LOADER_OP_BNE: begin
                word_c = {cmd.imm[12], cmd.imm[10:5], cmd.rs2, cmd.rs1, F3_BNE,
                          cmd.imm[4:1], cmd.imm[11], INST_TYPE_B};
                misaligned_c = cmd.imm[0];
            end
            LOADER_OP_JAL: begin
                word_c = {cmd.imm[20], cmd.imm[10:1], cmd.imm[11], cmd.imm[19:12],
                          cmd.rd, INST_JAL};
                misaligned_c = cmd.imm[0];
            end
            LOADER_OP_LUI: word_c = {cmd.imm[31:12], cmd.rd, INST_LUI};
            default:       illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_loader.sv
// Streams symbolic commands into instruction memory from word 0 upward,
// one encoded RV32I word per accepted command, without wrapping.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CPU_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_rs1,
    input  logic [4:0]            cmd_rs2,
    input  logic [31:0]           cmd_imm,
    input  logic                  cmd_last,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [CPU_WIDTH-1:0]  mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   inst_cnt
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    loader_state_e         state_q;
    loader_state_e         state_d;
    loader_cmd_t           cmd_c;
    logic [INST_WIDTH-1:0] enc_word_c;
    logic                  illegal_c;
    logic                  misaligned_c;
    logic                  accept_c;
    logic                  at_top_c;
    logic [ADDR_WIDTH-1:0] ptr_c;

    assign cmd_c = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2, imm: cmd_imm};

    inst_loader_encode u_encode (
        .cmd          (cmd_c),
        .word_c       (enc_word_c),
        .illegal_c    (illegal_c),
        .misaligned_c (misaligned_c)
    );

    // The count never exceeds capacity, so its low bits double as the write pointer.
    assign ptr_c     = inst_cnt[ADDR_WIDTH-1:0];
    assign at_top_c  = (ptr_c == {ADDR_WIDTH{1'b1}});
    assign cmd_ready = (state_q == ST_LOAD) && !start;
    assign accept_c  = cmd_valid && cmd_ready;
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else if (accept_c) begin
                    if (cmd_last) begin
                        state_d = ST_DONE;
                    end else if (at_top_c) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_DONE: if (start) state_d = ST_LOAD;
            ST_FULL: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port, counter and sticky error; a start never coincides with an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            inst_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            mem_wen <= accept_c;
            if (accept_c) begin
                mem_waddr <= ptr_c;
                mem_wdata <= CPU_WIDTH'(enc_word_c);
            end
            if (start) begin
                inst_cnt <= '0;
                err      <= 1'b0;
            end else if (accept_c) begin
                inst_cnt <= inst_cnt + CNT_WIDTH'(1);
                if (illegal_c || misaligned_c || (at_top_c && !cmd_last)) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized and directed bench for inst_loader against a session-level model.
module tb_inst_loader;

    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [4:0]    cmd_rd;
    logic [4:0]    cmd_rs1;
    logic [4:0]    cmd_rs2;
    logic [31:0]   cmd_imm;
    logic          cmd_last;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   inst_cnt;

    inst_loader #(.ADDR_WIDTH(AW), .CPU_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .cmd_last  (cmd_last),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .inst_cnt  (inst_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Session model: loading flag, words written, completion and error state.
    bit          m_load = 0;
    bit          m_done = 0;
    bit          m_err  = 0;
    int          m_cnt  = 0;
    logic [31:0] img [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_encode(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm,
                                       output logic [31:0] w, output bit bad);
        logic [31:0] d, s1, s2, f3;
        d  = 32'(rd);
        s1 = 32'(rs1);
        s2 = 32'(rs2);
        bad = 0;
        f3 = 0;
        if (op <= 4'd5) begin
            case (op)
                4'd2:    f3 = 4;
                4'd3:    f3 = 6;
                4'd4:    f3 = 7;
                4'd5:    f3 = 1;
                default: f3 = 0;
            endcase
            w = ((op == 4'd1) ? 32'h4000_0000 : 32'h0) | (s2 << 20) | (s1 << 15)
              | (f3 << 12) | (d << 7) | 32'h33;
        end else if (op == 4'd6) begin
            w = ((imm & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h13;
        end else if (op == 4'd7) begin
            w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (s2 << 20)
              | (s1 << 15) | (32'd1 << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 1) << 7) | 32'h63;
            bad = imm[0];
        end else if (op == 4'd8) begin
            w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
              | (d << 7) | 32'h6F;
            bad = imm[0];
        end else if (op == 4'd9) begin
            w = (imm & 32'hFFFF_F000) | (d << 7) | 32'h37;
        end else begin
            w = 32'h13;
            bad = 1;
        end
    endfunction

    // One clock: drive inputs, predict, advance, compare every output.
    task automatic cycle(input bit s, input bit v, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input bit last);
        bit          acc;
        bit          bad;
        logic [31:0] e_data;
        int          e_addr;
        start = s; cmd_valid = v; cmd_op = op; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_last = last;
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(m_load && !s));
        acc    = m_load && !s && v;
        e_addr = m_cnt;
        e_data = 32'h0;
        bad    = 0;
        if (acc) ref_encode(op, rd, rs1, rs2, imm, e_data, bad);
        if (s) begin
            m_load = 1; m_done = 0; m_cnt = 0; m_err = 0;
        end else if (acc) begin
            m_cnt++;
            if (bad) m_err = 1;
            if (last) begin
                m_load = 0; m_done = 1;
            end else if (m_cnt == DEPTH) begin
                m_load = 0; m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        check("mem_wen", 32'(mem_wen), 32'(acc));
        if (acc) begin
            check("mem_waddr", 32'(mem_waddr), 32'(e_addr));
            check("mem_wdata", mem_wdata, e_data);
        end
        check("busy", 32'(busy), 32'(m_load));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("inst_cnt", 32'(inst_cnt), 32'(m_cnt));
        if (mem_wen) img[mem_waddr] = mem_wdata;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input bit last);
        cycle(0, 1, op, rd, rs1, rs2, imm, last);
    endtask

    task automatic pulse_start();
        for (int i = 0; i < DEPTH; i++) img[i] = 32'hDEAD_BEEF;
        cycle(1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0);
    endtask

    task automatic rand_cycle(input bit s);
        logic [3:0]  op;
        logic [31:0] imm;
        op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        imm = $urandom;
        if ((op == 4'd7 || op == 4'd8) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
        cycle(s, ($urandom_range(0, 3) != 0), op, 5'($urandom), 5'($urandom), 5'($urandom),
              imm, ($urandom_range(0, 6) == 0));
    endtask

    initial begin
        rst_n = 0; start = 0; cmd_valid = 0; cmd_op = 0; cmd_rd = 0;
        cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0; cmd_last = 0;
        #3;
        check("rst_wen", 32'(mem_wen), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", 32'(inst_cnt), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        #14;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Two R-type commands
        pulse_start();
        cmd(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        cmd(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1);
        idle();
        check("t1_w0", img[0], 32'h0020_81B3);
        check("t1_w1", img[1], 32'h4020_81B3);
        check("t1_cnt", 32'(inst_cnt), 2);
        check("t1_done", 32'(done), 1);
        check("t1_err", 32'(err), 0);

        // Immediate formats
        pulse_start();
        cmd(4'd6, 5'd1, 5'd0, 5'd0, 32'd5, 0);
        cmd(4'd7, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 0);
        cmd(4'd8, 5'd1, 5'd0, 5'd0, 32'd16, 0);
        cmd(4'd9, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1);
        check("t2_w0", img[0], 32'h0050_0093);
        check("t2_w1", img[1], 32'hFE20_9CE3);
        check("t2_w2", img[2], 32'h0100_00EF);
        check("t2_w3", img[3], 32'h1234_52B7);
        check("t2_err", 32'(err), 0);

        // Overfill: one command more than capacity, never last
        pulse_start();
        for (int i = 0; i <= DEPTH; i++) cmd(4'd6, 5'd1, 5'd0, 5'd0, 32'(i), 0);
        check("t3_ready", 32'(cmd_ready), 0);
        check("t3_err", 32'(err), 1);
        check("t3_cnt", 32'(inst_cnt), DEPTH);
        check("t3_top", img[DEPTH-1], 32'h0070_0093);

        // Last command landing exactly on the top address
        pulse_start();
        for (int i = 0; i < DEPTH; i++) cmd(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, (i == DEPTH - 1));
        check("t3b_done", 32'(done), 1);
        check("t3b_err", 32'(err), 0);

        // Illegal op then a normal one
        pulse_start();
        cmd(4'd15, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 0);
        cmd(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        idle();
        check("t4_w0", img[0], 32'h0000_0013);
        check("t4_w1", img[1], 32'h0020_81B3);
        check("t4_err", 32'(err), 1);

        // Restart mid-session with a command pending
        cycle(1, 1, 4'd1, 5'd9, 5'd9, 5'd9, 32'd0, 0);
        check("t5_err", 32'(err), 0);
        cmd(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1);
        check("t5_w0", img[0], 32'h0020_81B3);
        check("t5_cnt", 32'(inst_cnt), 1);

        // Asynchronous reset during a write burst
        pulse_start();
        cmd(4'd10, 5'd1, 5'd1, 5'd1, 32'd0, 0);
        cmd(4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0);
        #2;
        rst_n = 0;
        #1;
        check("ar_wen", 32'(mem_wen), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_done", 32'(done), 0);
        check("ar_err", 32'(err), 0);
        check("ar_cnt", 32'(inst_cnt), 0);
        check("ar_ready", 32'(cmd_ready), 0);
        m_load = 0; m_done = 0; m_err = 0; m_cnt = 0;
        start = 0; cmd_valid = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        cmd(4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0);
        cmd(4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0);

        // Random sessions, occasionally restarted mid-flight
        for (int s = 0; s < 200; s++) begin
            pulse_start();
            for (int c = 0; c < 24 && m_load; c++) rand_cycle($urandom_range(0, 40) == 0);
            for (int c = 0; c < 2; c++) rand_cycle(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
